mips_multicycle_control: RTL and testbench

Multicycle successor to the single-cycle main control decoder: a Moore FSM that sequences each MIPS instruction over 3–5+ cycles, driving the shared-ALU/shared-memory multicycle datapath. It sits beside the datapath, takes the opcode from the instruction register, and adds a memory wait handshake, optional ADDI/J support, illegal-opcode detection and an instruction-retire pulse.

---
 rtl/mips_ctrl_pkg.sv | 41 ++++
 rtl/mips_multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
// Holds the 4-bit state enum, the opcodes the controller decodes, and the
// ALUOp / ALUSrcB / PCSource mux encodings the datapath expects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;  // register B
  localparam logic [1:0] SRCB_FOUR  = 2'b01;  // constant 4 (PC increment)
  localparam logic [1:0] SRCB_IMM   = 2'b10;  // sign-extended immediate
  localparam logic [1:0] SRCB_IMMSH = 2'b11;  // immediate << 2 (branch offset)

  localparam logic [1:0] PCSRC_ALU    = 2'b00;  // ALU result this cycle
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // registered branch target
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // jump target

endpackage

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the shared-ALU / shared-memory multicycle MIPS datapath.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   opcode          - instruction-register opcode, sampled in DECODE and MEMADR
//   mem_ready       - memory access completes this cycle (FETCH/MEMRD/MEMWR)
//   PCWrite..ALUSrcA, ALUSrcB, ALUOp, PCSource - datapath controls
//   instr_done      - pulse in the last cycle of each retired instruction
//   illegal_op      - pulse in DECODE for an unsupported opcode
//   state_o         - current state encoding for debug
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter bit EN_ADDI  = 1'b1,
  parameter bit EN_JUMP  = 1'b1,
  parameter bit MEM_HS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [3:0]          state_o
);

  state_t stateQ;
  state_t stateNext;
  state_t target;
  logic   memReady;

  assign memReady = MEM_HS ? mem_ready : 1'b1;

  function automatic logic opIs(input logic [OPCODE_W-1:0] op, input logic [5:0] code);
    return op == OPCODE_W'(code);
  endfunction

  // Dispatch target out of DECODE; S_FETCH marks an unsupported opcode.
  function automatic state_t decodeTarget(input logic [OPCODE_W-1:0] op);
    state_t t;
    t = S_FETCH;
    if (opIs(op, OP_R))                             t = S_EXEC;
    else if (opIs(op, OP_LW) || opIs(op, OP_SW))    t = S_MEMADR;
    else if (opIs(op, OP_BEQ))                      t = S_BRANCH;
    else if (EN_ADDI && opIs(op, OP_ADDI))          t = S_ADDIEX;
    else if (EN_JUMP && opIs(op, OP_J))             t = S_JUMP;
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) stateQ <= S_FETCH;
    else        stateQ <= stateNext;
  end

  // Output decode and next state. Everything stays 0 while reset is held,
  // so an aborted instruction cannot emit a write strobe or retire pulse.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    stateNext   = S_FETCH;
    target      = decodeTarget(opcode);
    state_o     = rst_n ? stateQ : S_FETCH;
    if (rst_n) begin
      case (stateQ)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          // PC and IR load only on the completing cycle, so a stalled fetch
          // increments the PC exactly once.
          IRWrite   = memReady;
          PCWrite   = memReady;
          stateNext = memReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB    = SRCB_IMMSH;
          illegal_op = (target == S_FETCH);
          stateNext  = target;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          if (opIs(opcode, OP_SW))      stateNext = S_MEMWR;
          else if (opIs(opcode, OP_LW)) stateNext = S_MEMRD;
          else                          stateNext = S_FETCH;
        end
        S_MEMRD: begin
          MemRead   = 1'b1;
          IorD      = 1'b1;
          stateNext = memReady ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = memReady;
          stateNext  = memReady ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          ALUSrcA   = 1'b1;
          ALUOp     = ALUOP_FUNCT;
          stateNext = S_ALUWB;
        end
        S_ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          instr_done  = 1'b1;
        end
        S_ADDIEX: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_IMM;
          stateNext = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: stateNext = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: a default instance (M) and a
// gated instance (G: EN_ADDI=0, MEM_HS=0 with mem_ready tied low).
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode;
  logic       memReadyM;
  logic       memReadyG;

  logic mPCWrite, mPCWriteCond, mIorD, mMemRead, mMemWrite, mIRWrite;
  logic mMemtoReg, mRegDst, mRegWrite, mALUSrcA, mInstrDone, mIllegal;
  logic [1:0] mALUSrcB, mALUOp, mPCSource;
  logic [3:0] mState;
  logic gPCWrite, gPCWriteCond, gIorD, gMemRead, gMemWrite, gIRWrite;
  logic gMemtoReg, gRegDst, gRegWrite, gALUSrcA, gInstrDone, gIllegal;
  logic [1:0] gALUSrcB, gALUOp, gPCSource;
  logic [3:0] gState;

  logic [17:0] outM, outG;
  assign outM = {mPCWrite, mPCWriteCond, mIorD, mMemRead, mMemWrite, mIRWrite, mMemtoReg,
                 mRegDst, mRegWrite, mALUSrcA, mALUSrcB, mALUOp, mPCSource, mInstrDone, mIllegal};
  assign outG = {gPCWrite, gPCWriteCond, gIorD, gMemRead, gMemWrite, gIRWrite, gMemtoReg,
                 gRegDst, gRegWrite, gALUSrcA, gALUSrcB, gALUOp, gPCSource, gInstrDone, gIllegal};

  localparam int B_PCW = 17, B_PCWC = 16, B_IORD = 15, B_MRD = 14, B_MWR = 13, B_IRW = 12;
  localparam int B_M2R = 11, B_RDST = 10, B_RW = 9, B_SRCA = 8, B_DONE = 1, B_ILL = 0;

  mips_multicycle_control dutM (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(memReadyM),
    .PCWrite(mPCWrite), .PCWriteCond(mPCWriteCond), .IorD(mIorD), .MemRead(mMemRead),
    .MemWrite(mMemWrite), .IRWrite(mIRWrite), .MemtoReg(mMemtoReg), .RegDst(mRegDst),
    .RegWrite(mRegWrite), .ALUSrcA(mALUSrcA), .ALUSrcB(mALUSrcB), .ALUOp(mALUOp),
    .PCSource(mPCSource), .instr_done(mInstrDone), .illegal_op(mIllegal), .state_o(mState));

  mips_multicycle_control #(.OPCODE_W(6), .EN_ADDI(1'b0), .EN_JUMP(1'b1), .MEM_HS(1'b0)) dutG (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(memReadyG),
    .PCWrite(gPCWrite), .PCWriteCond(gPCWriteCond), .IorD(gIorD), .MemRead(gMemRead),
    .MemWrite(gMemWrite), .IRWrite(gIRWrite), .MemtoReg(gMemtoReg), .RegDst(gRegDst),
    .RegWrite(gRegWrite), .ALUSrcA(gALUSrcA), .ALUSrcB(gALUSrcB), .ALUOp(gALUOp),
    .PCSource(gPCSource), .instr_done(gInstrDone), .illegal_op(gIllegal), .state_o(gState));

  int checks = 0;
  int failures = 0;
  int cycles;
  logic [17:0] trace [0:63];
  logic [3:0]  stTr  [0:63];

  // Runs one instruction starting in FETCH; mem_ready is low for fw FETCH
  // cycles and mw MEMRD/MEMWR cycles. Stops on return to FETCH or 40 cycles.
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input bit useG);
    int fLeft, mLeft;
    logic [3:0] st, nst;
    logic mr;
    fLeft = fw; mLeft = mw; cycles = 0;
    do begin
      @(negedge clk);
      st = useG ? gState : mState;
      opcode = op;
      mr = 1'b1;
      if (st == S_FETCH) begin
        mr = (fLeft == 0); if (fLeft > 0) fLeft--;
      end else if (st == S_MEMRD || st == S_MEMWR) begin
        mr = (mLeft == 0); if (mLeft > 0) mLeft--;
      end
      if (!useG) memReadyM = mr;
      #1;
      trace[cycles] = useG ? outG : outM;
      stTr[cycles]  = st;
      cycles++;
      @(posedge clk); #1;
      nst = useG ? gState : mState;
    end while (!(nst == S_FETCH && st != S_FETCH) && cycles < 40);
  endtask

  function automatic logic [63:0] maskOf(input int b);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < cycles; i++) if (trace[i][b]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic applyReset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; opcode = OP_LW; memReadyM = 1'b1; memReadyG = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if ({outM, outG} !== 36'd0) begin failures++; $display("FAIL reset_outputs cyc=%0d got=%h want=0", i, {outM, outG}); end
      checks++; if ({mState, gState} !== 8'h00) begin failures++; $display("FAIL reset_state cyc=%0d got=%h want=00", i, {mState, gState}); end
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_lw;
    runInstr(OP_LW, 0, 0, 1'b0);
    checks++; if (cycles !== 5) begin failures++; $display("FAIL lw_cycles got=%0d want=5", cycles); end
    checks++; if ({stTr[0], stTr[1], stTr[2], stTr[3], stTr[4]} !== 20'h01234) begin failures++; $display("FAIL lw_states got=%h want=01234", {stTr[0], stTr[1], stTr[2], stTr[3], stTr[4]}); end
    checks++; if (maskOf(B_RW) !== 64'h10) begin failures++; $display("FAIL lw_regwrite got=%h want=10", maskOf(B_RW)); end
    checks++; if (maskOf(B_M2R) !== 64'h10) begin failures++; $display("FAIL lw_memtoreg got=%h want=10", maskOf(B_M2R)); end
    checks++; if (maskOf(B_DONE) !== 64'h10) begin failures++; $display("FAIL lw_done got=%h want=10", maskOf(B_DONE)); end
    checks++; if (maskOf(B_MRD) !== 64'h09) begin failures++; $display("FAIL lw_memread got=%h want=09", maskOf(B_MRD)); end
    checks++; if (maskOf(B_IORD) !== 64'h08) begin failures++; $display("FAIL lw_iord got=%h want=08", maskOf(B_IORD)); end
    checks++; if (trace[2][7:6] !== 2'b10 || trace[2][B_SRCA] !== 1'b1) begin failures++; $display("FAIL lw_memadr_srcs got=%b want=110", {trace[2][B_SRCA], trace[2][7:6]}); end
  endtask

  task automatic test_wait_states;
    runInstr(OP_SW, 2, 3, 1'b0);
    checks++; if (cycles !== 9) begin failures++; $display("FAIL sw_wait_cycles got=%0d want=9", cycles); end
    checks++; if (maskOf(B_PCW) !== 64'h4) begin failures++; $display("FAIL sw_pcwrite got=%h want=4", maskOf(B_PCW)); end
    checks++; if (maskOf(B_IRW) !== 64'h4) begin failures++; $display("FAIL sw_irwrite got=%h want=4", maskOf(B_IRW)); end
    checks++; if (maskOf(B_MWR) !== 64'h1E0) begin failures++; $display("FAIL sw_memwrite got=%h want=1e0", maskOf(B_MWR)); end
    checks++; if (maskOf(B_DONE) !== 64'h100) begin failures++; $display("FAIL sw_done got=%h want=100", maskOf(B_DONE)); end
    checks++; if (trace[0][7:6] !== 2'b01) begin failures++; $display("FAIL fetch_srcb got=%b want=01", trace[0][7:6]); end
  endtask

  task automatic test_back_to_back;
    runInstr(OP_R, 0, 0, 1'b0);
    checks++; if (cycles !== 4) begin failures++; $display("FAIL r_cycles got=%0d want=4", cycles); end
    checks++; if (trace[2][5:4] !== 2'b10) begin failures++; $display("FAIL r_aluop got=%b want=10", trace[2][5:4]); end
    checks++; if (maskOf(B_RDST) !== 64'h8 || maskOf(B_RW) !== 64'h8) begin failures++; $display("FAIL r_writeback got=%h/%h want=8/8", maskOf(B_RDST), maskOf(B_RW)); end
    runInstr(OP_BEQ, 0, 0, 1'b0);
    checks++; if (cycles !== 3) begin failures++; $display("FAIL beq_cycles got=%0d want=3", cycles); end
    checks++; if (trace[1][7:6] !== 2'b11) begin failures++; $display("FAIL decode_srcb got=%b want=11", trace[1][7:6]); end
    checks++; if ({trace[2][B_PCWC], trace[2][3:2], trace[2][5:4]} !== 5'b10101) begin failures++; $display("FAIL beq_branch got=%b want=10101", {trace[2][B_PCWC], trace[2][3:2], trace[2][5:4]}); end
    checks++; if (maskOf(B_DONE) !== 64'h4) begin failures++; $display("FAIL beq_done got=%h want=4", maskOf(B_DONE)); end
    runInstr(OP_J, 0, 0, 1'b0);
    checks++; if (cycles !== 3) begin failures++; $display("FAIL j_cycles got=%0d want=3", cycles); end
    checks++; if (trace[2][3:2] !== 2'b10) begin failures++; $display("FAIL j_pcsource got=%b want=10", trace[2][3:2]); end
    checks++; if (maskOf(B_PCW) !== 64'h5) begin failures++; $display("FAIL j_pcwrite got=%h want=5", maskOf(B_PCW)); end
  endtask

  task automatic test_addi;
    runInstr(OP_ADDI, 0, 0, 1'b0);
    checks++; if (cycles !== 4) begin failures++; $display("FAIL addi_cycles got=%0d want=4", cycles); end
    checks++; if (trace[2][7:6] !== 2'b10) begin failures++; $display("FAIL addi_srcb got=%b want=10", trace[2][7:6]); end
    checks++; if (maskOf(B_RW) !== 64'h8 || maskOf(B_RDST) !== 64'h0) begin failures++; $display("FAIL addi_regwrite got=%h/%h want=8/0", maskOf(B_RW), maskOf(B_RDST)); end
  endtask

  task automatic test_illegal;
    runInstr(6'b111111, 0, 0, 1'b0);
    checks++; if (cycles !== 2) begin failures++; $display("FAIL illegal_cycles got=%0d want=2", cycles); end
    checks++; if (maskOf(B_ILL) !== 64'h2 || maskOf(B_DONE) !== 64'h0) begin failures++; $display("FAIL illegal_pulse got=%h/%h want=2/0", maskOf(B_ILL), maskOf(B_DONE)); end
  endtask

  task automatic test_gating;
    applyReset(2);
    runInstr(OP_ADDI, 0, 0, 1'b1);
    checks++; if (cycles !== 2) begin failures++; $display("FAIL gated_addi_cycles got=%0d want=2", cycles); end
    checks++; if (maskOf(B_ILL) !== 64'h2) begin failures++; $display("FAIL gated_addi_illegal got=%h want=2", maskOf(B_ILL)); end
    checks++; if (maskOf(B_RW) !== 64'h0) begin failures++; $display("FAIL gated_addi_regwrite got=%h want=0", maskOf(B_RW)); end
  endtask

  task automatic test_no_handshake;
    runInstr(OP_LW, 0, 0, 1'b1);
    checks++; if (cycles !== 5) begin failures++; $display("FAIL nohs_lw_cycles got=%0d want=5", cycles); end
    checks++; if (maskOf(B_PCW) !== 64'h1 || maskOf(B_DONE) !== 64'h10) begin failures++; $display("FAIL nohs_lw_strobes got=%h/%h want=1/10", maskOf(B_PCW), maskOf(B_DONE)); end
  endtask

  task automatic test_abort;
    applyReset(2);
    opcode = OP_LW;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); memReadyM = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (mState !== S_MEMRD) begin failures++; $display("FAIL abort_setup got=%0d want=%0d", mState, S_MEMRD); end
    @(negedge clk); memReadyM = 1'b1; rst_n = 1'b0; #1;
    checks++; if (outM !== 18'd0) begin failures++; $display("FAIL abort_outputs got=%h want=0", outM); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); memReadyM = 1'b0; #1;
    checks++; if (mState !== S_FETCH) begin failures++; $display("FAIL abort_state got=%0d want=0", mState); end
    checks++; if ({mRegWrite, mInstrDone, mMemRead} !== 3'b001) begin failures++; $display("FAIL abort_after got=%b want=001", {mRegWrite, mInstrDone, mMemRead}); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_wait_states();
    test_back_to_back();
    test_addi();
    test_illegal();
    test_gating();
    test_no_handshake();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
